// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encoding,
// opcodes, ALU operation codes, datapath mux selects and the control word.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_EXEC_R    = 4'd6,
      ST_R_WB      = 4'd7,
      ST_EXEC_I    = 4'd8,
      ST_I_WB      = 4'd9,
      ST_BRANCH    = 4'd10,
      ST_JUMP      = 4'd11
   } state_e;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   // Same encodings as the single-cycle control and the ALU control block.
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_LUI = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_R   = 3'b111;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUB_B      = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_I,
      CLS_MEM,
      CLS_BR,
      CLS_J,
      CLS_ILL
   } op_class_e;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   // Groups opcodes by the execution path they take after DECODE.
   function automatic op_class_e classify(input logic [5:0] op);
      case (op)
         OP_R:                    return CLS_R;
         OP_ADDI, OP_ORI, OP_LUI: return CLS_I;
         OP_LW, OP_SW:            return CLS_MEM;
         OP_BEQ, OP_BNE:          return CLS_BR;
         OP_J:                    return CLS_J;
         default:                 return CLS_ILL;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_control_decoder.sv
// Combinational Moore output decode: maps the current state (plus opcode,
// ALU zero flag and memory ready where relevant) to the datapath control word.
module mc_control_decoder
   import mips_mc_pkg::*;
#(
   parameter int OPCODE_WIDTH = 6
) (
   input  state_e                  state_i,
   input  logic [OPCODE_WIDTH-1:0] opcode_i,
   input  logic                    zero_i,
   input  logic                    ready_i,
   output ctrl_t                   ctrl_o
);

   logic [5:0] op6;

   assign op6 = 6'(opcode_i);

   // Every field defaults to 0; each state raises only what it needs.
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = ALUB_FOUR;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.pc_src    = PC_SRC_ALU;
            ctrl_o.ir_write  = ready_i;
            ctrl_o.pc_write  = ready_i;
         end
         ST_DECODE: begin
            ctrl_o.alu_src_b = ALUB_IMM_SH;
            ctrl_o.alu_op    = ALU_ADD;
            if (classify(op6) == CLS_ILL) begin
               ctrl_o.illegal_op = 1'b1;
               ctrl_o.instr_done = 1'b1;
            end
         end
         ST_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         ST_MEM_READ: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         ST_MEM_WRITE: begin
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.i_or_d     = 1'b1;
            ctrl_o.instr_done = ready_i;
         end
         ST_EXEC_R: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_B;
            ctrl_o.alu_op    = ALU_R;
         end
         ST_R_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         ST_EXEC_I: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_IMM;
            case (op6)
               OP_ORI:  ctrl_o.alu_op = ALU_OR;
               OP_LUI:  ctrl_o.alu_op = ALU_LUI;
               default: ctrl_o.alu_op = ALU_ADD;
            endcase
         end
         ST_I_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alu_src_b  = ALUB_B;
            ctrl_o.alu_op     = ALU_SUB;
            ctrl_o.pc_src     = PC_SRC_ALUOUT;
            ctrl_o.instr_done = 1'b1;
            ctrl_o.pc_write   = ((op6 == OP_BEQ) &&  zero_i) ||
                                ((op6 == OP_BNE) && !zero_i);
         end
         ST_JUMP: begin
            ctrl_o.pc_src     = PC_SRC_JUMP;
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: state register and next-state logic.
//
// state      | meaning
// -----------+------------------------------------------------
// FETCH    0 | read instruction at PC, PC+4 -> PC when ready
// DECODE   1 | branch target -> ALUOut, dispatch on opcode
// MEM_ADDR 2 | A + imm -> ALUOut (LW/SW effective address)
// MEM_READ 3 | read data memory, wait for ready
// MEM_WB   4 | MDR -> rt
// MEM_WRITE5 | write data memory, wait for ready
// EXEC_R   6 | A funct B
// R_WB     7 | ALUOut -> rd
// EXEC_I   8 | A op imm (ADDI/ORI/LUI)
// I_WB     9 | ALUOut -> rt
// BRANCH  10 | compare A,B; load PC from ALUOut if taken
// JUMP    11 | load PC with jump target
module multi_cycle_control
   import mips_mc_pkg::*;
#(
   parameter int OPCODE_WIDTH = 6,
   parameter int ALU_OP_WIDTH = 3,
   parameter int MEM_WAIT_EN  = 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [OPCODE_WIDTH-1:0] opcode_i,
   input  logic                    zero_i,
   input  logic                    mem_ready_i,
   output logic                    pc_write_o,
   output logic [1:0]              pc_src_o,
   output logic                    i_or_d_o,
   output logic                    mem_read_o,
   output logic                    mem_write_o,
   output logic                    ir_write_o,
   output logic                    reg_dst_o,
   output logic                    mem_to_reg_o,
   output logic                    reg_write_o,
   output logic                    alu_src_a_o,
   output logic [1:0]              alu_src_b_o,
   output logic [ALU_OP_WIDTH-1:0] alu_op_o,
   output logic                    instr_done_o,
   output logic                    illegal_op_o,
   output logic [3:0]              state_o
);

   localparam logic WAIT_EN = (MEM_WAIT_EN != 0);

   state_e state_q, state_d;
   logic   ready;
   ctrl_t  dec_ctrl;
   ctrl_t  ctrl;

   assign ready = mem_ready_i | ~WAIT_EN;

   mc_control_decoder #(
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_decoder (
      .state_i  (state_q),
      .opcode_i (opcode_i),
      .zero_i   (zero_i),
      .ready_i  (ready),
      .ctrl_o   (dec_ctrl)
   );

   // State register; reset lands in FETCH and abandons any instruction in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing; unused codes fall back to FETCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:     if (ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (classify(6'(opcode_i)))
               CLS_MEM: state_d = ST_MEM_ADDR;
               CLS_R:   state_d = ST_EXEC_R;
               CLS_I:   state_d = ST_EXEC_I;
               CLS_BR:  state_d = ST_BRANCH;
               CLS_J:   state_d = ST_JUMP;
               default: state_d = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR:  state_d = (6'(opcode_i) == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ:  if (ready) state_d = ST_MEM_WB;
         ST_MEM_WB:    state_d = ST_FETCH;
         ST_MEM_WRITE: if (ready) state_d = ST_FETCH;
         ST_EXEC_R:    state_d = ST_R_WB;
         ST_R_WB:      state_d = ST_FETCH;
         ST_EXEC_I:    state_d = ST_I_WB;
         ST_I_WB:      state_d = ST_FETCH;
         ST_BRANCH:    state_d = ST_FETCH;
         ST_JUMP:      state_d = ST_FETCH;
         default:      state_d = ST_FETCH;
      endcase
   end

   // Reset silences every strobe immediately, even before the state register updates.
   always_comb begin
      ctrl = dec_ctrl;
      if (reset_i) ctrl = '0;
   end

   assign pc_write_o   = ctrl.pc_write;
   assign pc_src_o     = ctrl.pc_src;
   assign i_or_d_o     = ctrl.i_or_d;
   assign mem_read_o   = ctrl.mem_read;
   assign mem_write_o  = ctrl.mem_write;
   assign ir_write_o   = ctrl.ir_write;
   assign reg_dst_o    = ctrl.reg_dst;
   assign mem_to_reg_o = ctrl.mem_to_reg;
   assign reg_write_o  = ctrl.reg_write;
   assign alu_src_a_o  = ctrl.alu_src_a;
   assign alu_src_b_o  = ctrl.alu_src_b;
   assign alu_op_o     = ALU_OP_WIDTH'(ctrl.alu_op);
   assign instr_done_o = ctrl.instr_done;
   assign illegal_op_o = ctrl.illegal_op;
   assign state_o      = reset_i ? 4'd0 : state_q;

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit.
- A Moore FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- It drives the shared-memory multi-cycle datapath: PC, IR, A/B, ALUOut and MDR registers.
- Adds LW/SW/BEQ/BNE/J, variable memory wait states, illegal-opcode detection and an instruction-retire pulse.

Parameters:
- OPCODE_WIDTH, 6, width of opcode_i.
- ALU_OP_WIDTH, 3, width of alu_op_o; package encodings are zero-extended to this width.
- MEM_WAIT_EN, 1, 1 = honour mem_ready_i; 0 = memory treated as always ready.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- opcode_i  in  OPCODE_WIDTH  IR[31:26], stable from DECODE until retire
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  PC load enable (already resolved for branches)
- pc_src_o  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target
- i_or_d_o  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- ir_write_o  out  1  IR load enable
- reg_dst_o  out  1  write-register select: 1 rd, 0 rt
- mem_to_reg_o  out  1  write-data select: 1 MDR, 0 ALUOut
- reg_write_o  out  1  register-file write enable
- alu_src_a_o  out  1  ALU A select: 0 PC, 1 A
- alu_src_b_o  out  2  ALU B select: 00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
- alu_op_o  out  ALU_OP_WIDTH  ALU operation
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op_o  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state_o  out  4  current state, for debug and verification

Behaviour:
- Supported opcodes:
  - R 0x00, ADDI 0x08, ORI 0x0D, LUI 0x0F
  - LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02
- ALU op encodings:
  - R 3'b111, ADD 3'b100, OR 3'b001, LUI 3'b010, SUB 3'b011
- Reset:
  - Synchronous; at the next clk_i edge with reset_i high, state is FETCH.
  - While reset_i is high, every output is forced to 0 regardless of state.
  - Reset asserted mid-instruction abandons it; no write strobe is issued after the asserting edge.
- Outputs are a pure decode of state, plus zero_i and mem_ready_i where noted. Any output not listed for a state is 0.
- States and transitions:
  - FETCH(0):
    - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
    - ir_write and pc_write equal ready, where ready = mem_ready_i | ~MEM_WAIT_EN.
    - Stays in FETCH while not ready; goes to DECODE when ready.
  - DECODE(1):
    - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD; computes the branch target into ALUOut.
    - Next state by opcode:
      - LW/SW -> MEM_ADDR
      - R -> EXEC_R
      - ADDI/ORI/LUI -> EXEC_I
      - BEQ/BNE -> BRANCH
      - J -> JUMP
      - any other opcode -> FETCH, with illegal_op=1 and instr_done=1
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=ADD. LW -> MEM_READ; SW -> MEM_WRITE.
  - MEM_READ(3): mem_read=1, i_or_d=1. Holds until ready, then -> MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. -> FETCH.
  - MEM_WRITE(5): mem_write=1, i_or_d=1. Holds until ready; instr_done=ready. Then -> FETCH.
  - EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=R. -> R_WB.
  - R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. -> FETCH.
  - EXEC_I(8):
    - alu_src_a=1, alu_src_b=10.
    - alu_op = ADD for ADDI, OR for ORI, LUI for LUI.
    - -> I_WB.
  - I_WB(9): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. -> FETCH.
  - BRANCH(10):
    - alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, instr_done=1.
    - pc_write = (BEQ & zero_i) | (BNE & ~zero_i).
    - -> FETCH.
  - JUMP(11): pc_src=10, pc_write=1, instr_done=1. -> FETCH.
- Codes 12-15 are unreachable; if entered, the FSM returns to FETCH with all outputs 0.
- Cycle counts with zero wait states: R/I-ALU/SW 4, LW 5, BEQ/BNE/J 3, illegal 2. Each wait cycle adds 1.
- mem_read_o and mem_write_o are never both 1.
- Exactly one instr_done pulse per instruction.

Decomposition:
- Package mips_mc_pkg holds:
  - the state enum (4-bit)
  - opcode localparams
  - ALU op encodings (shared with the single-cycle control and the ALU control)
  - the pc_src and alu_src_b select encodings
- One sub-module, mc_control_decoder: purely combinational mapping of (state, opcode, zero, ready) to the output control word.
- The top level holds only the state register and next-state logic.

Test Plan:
- Reset for 2 cycles, then release with mem_ready_i=1 -> state_o=0, FETCH outputs: mem_read=1, ir_write=1, pc_write=1.
- ADDI (0x08), memory always ready -> states 0,1,8,9; I_WB has reg_write=1, reg_dst=0; instr_done on cycle 4 only.
- LW (0x23) with mem_ready_i low for 2 cycles in both FETCH and MEM_READ -> 9 cycles; ir_write only on the ready cycle; mem_to_reg=1 in MEM_WB.
- BEQ with zero_i=1, then BNE with zero_i=1 -> pc_write=1 with pc_src=01, then pc_write=0; each takes 3 cycles.
- Opcode 0x3F -> illegal_op and instr_done pulse once in DECODE, next state FETCH, no write strobes.
- SW with mem_ready_i low, then reset_i asserted in MEM_WRITE -> all outputs 0 while reset is high, mem_write never seen with ready, state FETCH afterwards.
